// File: rtl/match_action_pkg.sv
// match_action_pkg: shared definitions for the match-action stage.
//   NO_HEADER      marker for an absent header slot in the offset vector
//   ma_state_t     FSM states (MA_STATE_FREE/READ/WRITE/DONE), MA_STATE_BUS wide
//   ma_op_t        action op codes (MA_OP_NOP/SET/DROP)
//   ma_key_t       key-field configuration
//   ma_entry_t     one match-table entry
//   norm_width()   maps a configured width to the 1/2/4-byte access size
//   width_mask()   low-byte mask for a 1/2/4-byte access
package match_action_pkg;

    localparam logic [31:0] NO_HEADER    = 32'hFFFF_FFFF;
    localparam int          MA_STATE_BUS = 2;

    typedef enum logic [MA_STATE_BUS-1:0] {
        MA_STATE_FREE  = 2'd0,
        MA_STATE_READ  = 2'd1,
        MA_STATE_WRITE = 2'd2,
        MA_STATE_DONE  = 2'd3
    } ma_state_t;

    typedef enum logic [1:0] {
        MA_OP_NOP  = 2'd0,
        MA_OP_SET  = 2'd1,
        MA_OP_DROP = 2'd2,
        MA_OP_RSVD = 2'd3
    } ma_op_t;

    typedef struct packed {
        logic [31:0] hdr_id;
        logic [31:0] offset;
        logic [31:0] width;
    } ma_key_t;

    typedef struct packed {
        logic        valid;
        ma_op_t      op;
        logic [31:0] match_val;
        logic [31:0] action_val;
    } ma_entry_t;

    // Anything other than 1 or 2 bytes is a full-word access.
    function automatic logic [3:0] norm_width(input logic [31:0] w);
        case (w)
            32'd1:   return 4'd1;
            32'd2:   return 4'd2;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [31:0] width_mask(input logic [3:0] w);
        case (w)
            4'd1:    return 32'h0000_00FF;
            4'd2:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/match_action_lookup.sv
// ma_lookup: combinational priority matcher.
//   field       right-aligned key field read from memory
//   width       access size in bytes (1/2/4); only the low width*8 bits compare
//   match_vals  per-entry match values
//   valid       per-entry valid flags
//   hit         some valid entry matched
//   idx         lowest matching entry index (0 when no hit)
module ma_lookup
    import match_action_pkg::*;
#(
    parameter int TABLE_SIZE = 4,
    parameter int IDX_W      = 2
) (
    input  logic [31:0]           field,
    input  logic [3:0]            width,
    input  logic [31:0]           match_vals [TABLE_SIZE],
    input  logic [TABLE_SIZE-1:0] valid,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);

    logic [31:0] mask;

    // Scan from the top entry down so the last assignment is the lowest match.
    always_comb begin
        mask = width_mask(width);
        hit  = 1'b0;
        idx  = '0;
        for (int unsigned i = TABLE_SIZE; i > 0; i--) begin
            if (valid[i-1] && (((match_vals[i-1] ^ field) & mask) == '0)) begin
                hit = 1'b1;
                idx = IDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/match_action.sv
// match_action: single-table match-action stage behind the header parser.
// Reads one configured key field of the packet, matches it against a small
// priority table and applies NOP / SET (write back) / DROP.
//   clk, rst            clock, synchronous active-high reset
//   start_i             level start from the parser (its ready_o)
//   parsed_hdrs_i/_o    header offset vector in / registered copy out (slot 0 in MSBs)
//   mem_*               packet memory port (registered ce/we/addr/width/data, mem_data_i same cycle)
//   ready_o             verdict valid; hit_o / hit_idx_o / drop_o the verdict
//   mod_*               configuration write port (key config or table entry), FREE only
// Optional build macro MA_HIT_COUNTER_EN adds per-entry saturating hit counters
// readable through stat_idx_i / stat_cnt_o.
module match_action
    import match_action_pkg::*;
#(
    parameter int NUM_HEADERS = 2,
    parameter int TABLE_SIZE  = 4,
    parameter int WORD_WIDTH  = 32,
    localparam int IDX_W      = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic [WORD_WIDTH*NUM_HEADERS-1:0] parsed_hdrs_i,
    output logic                              mem_ce_o,
    output logic                              mem_we_o,
    output logic [31:0]                       mem_addr_o,
    output logic [3:0]                        mem_width_o,
    output logic [31:0]                       mem_data_o,
    input  logic [31:0]                       mem_data_i,
    output logic                              ready_o,
    output logic                              hit_o,
    output logic [IDX_W-1:0]                  hit_idx_o,
    output logic                              drop_o,
    output logic [WORD_WIDTH*NUM_HEADERS-1:0] parsed_hdrs_o,
    input  logic                              mod_start_i,
    input  logic                              mod_sel_i,
    input  logic [31:0]                       mod_idx_i,
    input  logic [31:0]                       mod_data0_i,
    input  logic [31:0]                       mod_data1_i,
    input  logic [31:0]                       mod_data2_i
`ifdef MA_HIT_COUNTER_EN
   ,input  logic [31:0]                       stat_idx_i,
    output logic [31:0]                       stat_cnt_o
`endif
);

    localparam logic [WORD_WIDTH-1:0] NO_HDR = WORD_WIDTH'(NO_HEADER);

    ma_state_t                         state_q, state_d;
    logic                              ce_q, ce_d, we_q, we_d;
    logic [31:0]                       addr_q, addr_d, data_q, data_d;
    logic [3:0]                        width_q, width_d;
    logic                              ready_q, ready_d, hit_q, hit_d, drop_q, drop_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [WORD_WIDTH*NUM_HEADERS-1:0] hdrs_q, hdrs_d;

    ma_key_t                           key_q;
    ma_entry_t                         entries [TABLE_SIZE];
    logic                              key_wr, entry_wr, count_hit;

    logic [WORD_WIDTH-1:0]             slot;
    logic                              slot_ok;
    logic [31:0]                       match_vals [TABLE_SIZE];
    logic [TABLE_SIZE-1:0]             valid_vec;
    logic                              lk_hit;
    logic [IDX_W-1:0]                  lk_idx;

    logic unused_mod_bits;
    assign unused_mod_bits = ^{mod_data2_i[31:9], mod_data2_i[7:2]};

    always_comb begin
        for (int unsigned i = 0; i < TABLE_SIZE; i++) begin
            match_vals[i] = entries[i].match_val;
            valid_vec[i]  = entries[i].valid;
        end
    end

    ma_lookup #(
        .TABLE_SIZE (TABLE_SIZE),
        .IDX_W      (IDX_W)
    ) u_lookup (
        .field      (mem_data_i),
        .width      (width_q),
        .match_vals (match_vals),
        .valid      (valid_vec),
        .hit        (lk_hit),
        .idx        (lk_idx)
    );

    // Header slot named by the key; slot_ok stays low for an out-of-range hdr_id.
    always_comb begin
        slot    = NO_HDR;
        slot_ok = 1'b0;
        for (int unsigned k = 0; k < NUM_HEADERS; k++) begin
            if (key_q.hdr_id == 32'(k)) begin
                slot    = parsed_hdrs_i[(NUM_HEADERS-1-k)*WORD_WIDTH +: WORD_WIDTH];
                slot_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ce_d      = ce_q;
        we_d      = we_q;
        addr_d    = addr_q;
        width_d   = width_q;
        data_d    = data_q;
        ready_d   = ready_q;
        hit_d     = hit_q;
        idx_d     = idx_q;
        drop_d    = drop_q;
        hdrs_d    = hdrs_q;
        key_wr    = 1'b0;
        entry_wr  = 1'b0;
        count_hit = 1'b0;

        case (state_q)
            MA_STATE_FREE: begin
                if (mod_start_i) begin
                    if (!mod_sel_i)                          key_wr   = 1'b1;
                    else if (mod_idx_i < 32'(TABLE_SIZE))    entry_wr = 1'b1;
                end else if (start_i) begin
                    ready_d = 1'b0;
                    hit_d   = 1'b0;
                    drop_d  = 1'b0;
                    hdrs_d  = parsed_hdrs_i;
                    if (!slot_ok || slot == NO_HDR) begin
                        ready_d = 1'b1;
                        state_d = MA_STATE_DONE;
                    end else begin
                        ce_d    = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = 32'(slot) + key_q.offset;
                        width_d = norm_width(key_q.width);
                        state_d = MA_STATE_READ;
                    end
                end
            end
            MA_STATE_READ: begin
                if (!lk_hit) begin
                    ce_d    = 1'b0;
                    ready_d = 1'b1;
                    state_d = MA_STATE_DONE;
                end else begin
                    hit_d     = 1'b1;
                    idx_d     = lk_idx;
                    count_hit = 1'b1;
                    case (entries[lk_idx].op)
                        MA_OP_SET: begin
                            we_d    = 1'b1;
                            data_d  = entries[lk_idx].action_val & width_mask(width_q);
                            state_d = MA_STATE_WRITE;
                        end
                        MA_OP_DROP: begin
                            drop_d  = 1'b1;
                            ce_d    = 1'b0;
                            ready_d = 1'b1;
                            state_d = MA_STATE_DONE;
                        end
                        default: begin
                            ce_d    = 1'b0;
                            ready_d = 1'b1;
                            state_d = MA_STATE_DONE;
                        end
                    endcase
                end
            end
            MA_STATE_WRITE: begin
                ce_d    = 1'b0;
                we_d    = 1'b0;
                ready_d = 1'b1;
                state_d = MA_STATE_DONE;
            end
            default: begin
                if (!start_i) state_d = MA_STATE_FREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MA_STATE_FREE;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            width_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            drop_q  <= 1'b0;
            hdrs_q  <= {NUM_HEADERS{NO_HDR}};
        end else begin
            state_q <= state_d;
            ce_q    <= ce_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            width_q <= width_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
            hdrs_q  <= hdrs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= '0;
            for (int unsigned i = 0; i < TABLE_SIZE; i++) entries[i] <= '0;
        end else begin
            if (key_wr)
                key_q <= '{hdr_id: mod_data0_i, offset: mod_data1_i, width: mod_data2_i};
            if (entry_wr)
                entries[mod_idx_i[IDX_W-1:0]] <= '{valid:      mod_data2_i[8],
                                                   op:         ma_op_t'(mod_data2_i[1:0]),
                                                   match_val:  mod_data0_i,
                                                   action_val: mod_data1_i};
        end
    end

`ifdef MA_HIT_COUNTER_EN
    logic [31:0] hit_cnt [TABLE_SIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < TABLE_SIZE; i++) hit_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < TABLE_SIZE; i++) begin
                if (entry_wr && mod_idx_i[IDX_W-1:0] == IDX_W'(i))
                    hit_cnt[i] <= '0;
                else if (count_hit && lk_idx == IDX_W'(i) && hit_cnt[i] != '1)
                    hit_cnt[i] <= hit_cnt[i] + 32'd1;
            end
        end
    end

    assign stat_cnt_o = (stat_idx_i < 32'(TABLE_SIZE)) ? hit_cnt[stat_idx_i[IDX_W-1:0]] : '0;
`endif

    assign mem_ce_o      = ce_q;
    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_width_o   = width_q;
    assign mem_data_o    = data_q;
    assign ready_o       = ready_q;
    assign hit_o         = hit_q;
    assign hit_idx_o     = idx_q;
    assign drop_o        = drop_q;
    assign parsed_hdrs_o = hdrs_q;

endmodule

// File: tb/tb_match_action.sv
// tb_match_action: randomized self-checking bench for match_action with a
// transaction-level reference model (key config, table, byte memory).
module tb_match_action;

    localparam int NH = 2;
    localparam int TS = 4;
    localparam int WW = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WW*NH-1:0]   parsed_in;
    logic               mem_ce, mem_we;
    logic [31:0]        mem_addr, mem_wdata, mem_rdata;
    logic [3:0]         mem_width;
    logic               ready, hit, drop;
    logic [1:0]         hit_idx;
    logic [WW*NH-1:0]   parsed_out;
    logic               mod_start, mod_sel;
    logic [31:0]        mod_idx, mod_d0, mod_d1, mod_d2;
`ifdef MA_HIT_COUNTER_EN
    logic [31:0]        stat_idx = '0;
    logic [31:0]        stat_cnt;
`endif

    always #5 clk = ~clk;

    match_action #(
        .NUM_HEADERS (NH),
        .TABLE_SIZE  (TS),
        .WORD_WIDTH  (WW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .parsed_hdrs_i (parsed_in),
        .mem_ce_o      (mem_ce),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_width_o   (mem_width),
        .mem_data_o    (mem_wdata),
        .mem_data_i    (mem_rdata),
        .ready_o       (ready),
        .hit_o         (hit),
        .hit_idx_o     (hit_idx),
        .drop_o        (drop),
        .parsed_hdrs_o (parsed_out),
        .mod_start_i   (mod_start),
        .mod_sel_i     (mod_sel),
        .mod_idx_i     (mod_idx),
        .mod_data0_i   (mod_d0),
        .mod_data1_i   (mod_d1),
        .mod_data2_i   (mod_d2)
`ifdef MA_HIT_COUNTER_EN
       ,.stat_idx_i    (stat_idx),
        .stat_cnt_o    (stat_cnt)
`endif
    );

    // Big-endian byte memory; read data is right-aligned.
    logic [7:0] mem [0:1023];

    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 4; i++)
            if (i < int'(mem_width))
                mem_rdata = (mem_rdata << 8) | 32'(mem[(mem_addr + 32'(i)) & 32'h3FF]);
    end

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] kh, ko, kw;
    bit          tvalid [TS];
    logic [31:0] tv [TS];
    logic [31:0] ta [TS];
    int          top [TS];
    int          m_idx;

    typedef struct {
        logic [31:0] addr;
        int          w;
        bit          we;
        logic [31:0] data;
    } acc_t;
    acc_t expq [$];
    acc_t e;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a, input int w);
        logic [31:0] v = '0;
        for (int i = 0; i < w; i++) v = (v << 8) | 32'(mem[(a + 32'(i)) & 32'h3FF]);
        return v;
    endfunction

    task automatic mwrite(input logic [31:0] a, input int w, input logic [31:0] v);
        for (int i = 0; i < w; i++) mem[(a + 32'(i)) & 32'h3FF] = 8'(v >> (8 * (w - 1 - i)));
    endtask

    // One clock: sample on the falling edge and check any memory access
    // against the next expected one.
    task automatic tick();
        @(negedge clk);
        if (mem_ce === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_mem_access: got addr=%0h we=%0b, required no access", mem_addr, mem_we);
            end else begin
                e = expq.pop_front();
                chk("acc_addr", 64'(mem_addr), 64'(e.addr));
                chk("acc_width", 64'(mem_width), 64'(e.w));
                chk("acc_we", 64'(mem_we), 64'(e.we));
                if (e.we) begin
                    chk("acc_data", 64'(mem_wdata), 64'(e.data));
                    if (mem_we === 1'b1) mwrite(mem_addr, int'(mem_width), mem_wdata);
                end
            end
        end
    endtask

    function automatic void model_reset();
        kh = '0; ko = '0; kw = '0; m_idx = 0;
        for (int i = 0; i < TS; i++) begin
            tvalid[i] = 0; tv[i] = '0; ta[i] = '0; top[i] = 0;
        end
    endfunction

    function automatic int eff_w(input logic [31:0] w);
        return (w == 1) ? 1 : (w == 2) ? 2 : 4;
    endfunction

    function automatic logic [31:0] wmask(input int w);
        return (w == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * w)) - 32'd1);
    endfunction

    function automatic logic [31:0] slot_of(input logic [63:0] h, input logic [31:0] id);
        return (id == 0) ? h[63:32] : h[31:0];
    endfunction

    // Predict the verdict of one packet and queue the memory accesses it needs.
    function automatic void predict(input logic [63:0] h, output int lat, output bit ehit, output bit edrop);
        int          w;
        logic [31:0] slot, a, m, f;
        ehit = 0; edrop = 0; lat = 1;
        if (kh >= NH) return;
        slot = slot_of(h, kh);
        if (slot == 32'hFFFF_FFFF) return;
        w = eff_w(kw);
        m = wmask(w);
        a = slot + ko;
        f = mread(a, w) & m;
        expq.push_back('{addr: a, w: w, we: 0, data: '0});
        lat = 2;
        for (int i = 0; i < TS; i++) begin
            if (tvalid[i] && ((tv[i] & m) == f)) begin
                ehit = 1;
                m_idx = i;
                if (top[i] == 1) begin
                    lat = 3;
                    expq.push_back('{addr: a, w: w, we: 1, data: ta[i] & m});
                end else if (top[i] == 2) begin
                    edrop = 1;
                end
                break;
            end
        end
    endfunction

    task automatic cfg(input bit sel, input logic [31:0] idx, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [31:0] d2);
        mod_start = 1; mod_sel = sel; mod_idx = idx; mod_d0 = d0; mod_d1 = d1; mod_d2 = d2;
        tick();
        mod_start = 0;
        if (!sel) begin
            kh = d0; ko = d1; kw = d2;
        end else if (idx < TS) begin
            tvalid[idx] = d2[8]; tv[idx] = d0; ta[idx] = d1; top[idx] = int'(d2[1:0]);
        end
    endtask

    // One packet: optional config write in the start cycle, optional ignored
    // config write while DONE, start held for two extra cycles, then released.
    task automatic run(input logic [63:0] h, input bit with_cfg, input logic [31:0] c0,
                       input logic [31:0] c1, input logic [31:0] c2, input bit poke,
                       output int lat, output bit ohit, output int oidx, output bit odrop);
        int elat;
        bit ehit, edrop;
        parsed_in = h;
        start = 1;
        if (with_cfg) begin
            mod_start = 1; mod_sel = 0; mod_idx = '0; mod_d0 = c0; mod_d1 = c1; mod_d2 = c2;
            kh = c0; ko = c1; kw = c2;
            tick();
            mod_start = 0;
            chk("cfg_first_no_access", 64'(mem_ce), 64'd0);
        end
        predict(h, elat, ehit, edrop);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (ready === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("latency", 64'(lat), 64'(elat));
        chk("hit", 64'(hit), 64'(ehit));
        chk("hit_idx", 64'(hit_idx), 64'(m_idx));
        chk("drop", 64'(drop), 64'(edrop));
        chk("parsed_hdrs", parsed_out, h);
        ohit = hit; oidx = int'(hit_idx); odrop = drop;
        for (int k = 0; k < 2; k++) begin
            if (poke && k == 0) begin
                mod_start = 1; mod_sel = 0; mod_d0 = 32'd0; mod_d1 = 32'h55; mod_d2 = 32'd1;
            end
            tick();
            mod_start = 0;
            chk("hold_ready", 64'(ready), 64'd1);
            chk("hold_no_access", 64'(mem_ce), 64'd0);
            chk("hold_hit", 64'(hit), 64'(ehit));
        end
        start = 0;
        tick();
        chk("ready_after_release", 64'(ready), 64'd1);
        chk("accesses_done", 64'(expq.size()), 64'd0);
        expq.delete();
        tick();
    endtask

    task automatic check_reset();
        chk("rst_ce", 64'(mem_ce), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_width", 64'(mem_width), 64'd0);
        chk("rst_data", 64'(mem_wdata), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_hit", 64'(hit), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        chk("rst_idx", 64'(hit_idx), 64'd0);
        chk("rst_hdrs", parsed_out, {64{1'b1}});
    endtask

    function automatic logic [31:0] pool(input int i);
        case (i)
            0:       return 32'h0000_0800;
            1:       return 32'h0000_0806;
            2:       return 32'h0000_86DD;
            3:       return 32'h1122_3344;
            default: return 32'h0000_0044;
        endcase
    endfunction

    int          lat, idx;
    bit          h_o, d_o;
    logic [31:0] h0, h1, slot, v;

    initial begin
        rst = 1; start = 0; parsed_in = '0; mod_start = 0; mod_sel = 0;
        mod_idx = '0; mod_d0 = '0; mod_d1 = '0; mod_d2 = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7);
        model_reset();
        repeat (3) tick();
        check_reset();
        rst = 0;
        tick();

        // SET hit: read 0x110 w2, write 0x86DD back.
        cfg(0, 0, 32'd1, 32'd2, 32'd2);
        cfg(1, 0, 32'h0800, 32'h86DD, 32'h101);
        mwrite(32'h110, 2, 32'h0800);
        run({32'h100, 32'h10E}, 0, 0, 0, 0, 0, lat, h_o, idx, d_o);
        chk("set_lat_lit", 64'(lat), 64'd3);
        chk("set_hit_lit", 64'(h_o), 64'd1);
        chk("set_idx_lit", 64'(idx), 64'd0);
        chk("set_mem_lit", 64'(mread(32'h110, 2)), 64'h86DD);

        // DROP on entry 2.
        cfg(1, 2, 32'h0806, 32'd0, 32'h102);
        mwrite(32'h110, 2, 32'h0806);
        run({32'h100, 32'h10E}, 0, 0, 0, 0, 0, lat, h_o, idx, d_o);
        chk("drop_lat_lit", 64'(lat), 64'd2);
        chk("drop_lit", 64'(d_o), 64'd1);
        chk("drop_idx_lit", 64'(idx), 64'd2);

        // Two matching entries: lower index (NOP) wins, no write.
        cfg(1, 0, 32'h0800, 32'd0, 32'h100);
        cfg(1, 1, 32'h0800, 32'h1234, 32'h101);
        mwrite(32'h110, 2, 32'h0800);
        run({32'h100, 32'h10E}, 0, 0, 0, 0, 0, lat, h_o, idx, d_o);
        chk("prio_idx_lit", 64'(idx), 64'd0);
        chk("prio_lat_lit", 64'(lat), 64'd2);
        chk("prio_mem_lit", 64'(mread(32'h110, 2)), 64'h0800);

        // Absent header.
        run({32'h100, 32'hFFFF_FFFF}, 0, 0, 0, 0, 0, lat, h_o, idx, d_o);
        chk("absent_lat_lit", 64'(lat), 64'd1);
        chk("absent_hit_lit", 64'(h_o), 64'd0);

        // Config and start together: new key {hdr 0, off 0x10, w 2} applies;
        // a config write while DONE is ignored by the next packet.
        run({32'h100, 32'h10E}, 1, 32'd0, 32'h10, 32'd2, 1, lat, h_o, idx, d_o);
        chk("cfgstart_lat_lit", 64'(lat), 64'd2);
        chk("cfgstart_hit_lit", 64'(h_o), 64'd1);
        run({32'h100, 32'h200}, 0, 0, 0, 0, 0, lat, h_o, idx, d_o);
        chk("done_cfg_ignored_lit", 64'(h_o), 64'd1);

        // Out-of-range entry index is ignored.
        cfg(1, 7, 32'h0800, 32'd0, 32'h102);
        run({32'h100, 32'h10E}, 0, 0, 0, 0, 0, lat, h_o, idx, d_o);

        // Reset while a SET hit is pending in READ.
        cfg(0, 0, 32'd1, 32'd2, 32'd2);
        cfg(1, 0, 32'h0800, 32'hBEEF, 32'h101);
        mwrite(32'h110, 2, 32'h0800);
        parsed_in = {32'h100, 32'h10E};
        start = 1;
        predict(parsed_in, lat, h_o, d_o);
        tick();
        chk("rst_abort_in_read", 64'(mem_ce), 64'd1);
        rst = 1;
        start = 0;
        tick();
        rst = 0;
        chk("rst_abort_write_pending", 64'(expq.size()), 64'd1);
        expq.delete();
        model_reset();
        check_reset();
        tick();
        tick();
        chk("rst_abort_mem", 64'(mread(32'h110, 2)), 64'h0800);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) < 2)
                cfg(0, 0, $urandom_range(0, 2), $urandom_range(0, 15), $urandom_range(0, 4));
            if ($urandom_range(0, 9) < 6)
                cfg(1, $urandom_range(0, 5), pool($urandom_range(0, 4)), $urandom,
                    {23'd0, ($urandom_range(0, 4) != 0), 6'd0, 2'($urandom_range(0, 3))});
            h0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'h100 + 32'($urandom_range(0, 31)) * 16;
            h1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'h100 + 32'($urandom_range(0, 31)) * 16;
            if (kh < NH && $urandom_range(0, 9) < 7) begin
                slot = slot_of({h0, h1}, kh);
                v = pool($urandom_range(0, 4));
                if (slot != 32'hFFFF_FFFF) mwrite(slot + ko, eff_w(kw), v);
            end
            run({h0, h1}, ($urandom_range(0, 9) == 0), $urandom_range(0, 1), $urandom_range(0, 15),
                $urandom_range(0, 4), ($urandom_range(0, 9) == 0), lat, h_o, idx, d_o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_action.md
Name: match_action

Overview:
- Single-table match-action stage directly downstream of the header parser.
- On start, takes the parser's per-header offset vector. Reads one configurable key field from packet memory and matches it against a small priority table.
- Applies the winning action: NOP, SET (write back the field) or DROP.
- Presents the verdict and the pass-through header vector to the next stage using the same start/ready level handshake as the parser.

Parameters:
- NUM_HEADERS, 2, headers per packet; slots in parsed_hdrs_i
- TABLE_SIZE, 4, match entries
- WORD_WIDTH, 32, header offset / data word width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start_i  in  1  level; parser ready_o
- parsed_hdrs_i  in  WORD_WIDTH*NUM_HEADERS  header addresses; slot 0 in MSBs; NO_HEADER = absent
- mem_ce_o  out  1  memory enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  32  byte address
- mem_width_o  out  4  access bytes (1/2/4)
- mem_data_o  out  32  write data, right-aligned
- mem_data_i  in  32  read data, right-aligned; valid in the same cycle the registered ce/addr are visible
- ready_o  out  1  verdict valid
- hit_o  out  1  some entry matched
- hit_idx_o  out  $clog2(TABLE_SIZE)  winning entry
- drop_o  out  1  packet to be dropped
- parsed_hdrs_o  out  WORD_WIDTH*NUM_HEADERS  registered copy of parsed_hdrs_i
- mod_start_i  in  1  config write strobe
- mod_sel_i  in  1  0 = key config, 1 = table entry
- mod_idx_i  in  32  entry index (mod_sel_i=1)
- mod_data0_i  in  32  key: hdr_id / entry: match value
- mod_data1_i  in  32  key: byte offset / entry: action value
- mod_data2_i  in  32  key: width bytes / entry: {valid[8], op[1:0]}

Behaviour:
- Reset (synchronous, active-high rst, clock clk):
  - mem_ce_o/we_o = 0; addr/width/data = 0.
  - ready_o, hit_o, drop_o = 0; hit_idx_o = 0; parsed_hdrs_o all NO_HEADER.
  - Key config = 0; all entries invalid.
  - State FREE. Reset mid-operation aborts with no write issued after the reset cycle.
- FREE:
  - If mod_start_i: write key config or entry[mod_idx_i]. mod_idx_i >= TABLE_SIZE is ignored.
  - mod_start_i has priority over start_i; start_i is level and is taken on a later cycle.
  - Else if start_i: clear ready_o, hit_o, drop_o; latch parsed_hdrs_i into parsed_hdrs_o.
    - If key hdr_id >= NUM_HEADERS or the selected slot == NO_HEADER: miss, ready_o=1, go to DONE.
    - Otherwise: ce=1, we=0, addr = slot + offset (32-bit wrap), width = key width; go to READ.
- Key width values other than 1 or 2 are treated as 4. Field = mem_data_i masked to the low width*8 bits.
- READ:
  - Compare the field against valid entries' match values masked to the same width. Lowest index wins.
  - Miss: ce=0, ready_o=1, go to DONE.
  - Hit: hit_o=1, hit_idx_o=idx, then by op:
    - op 0 NOP: ce=0, ready_o=1, go to DONE.
    - op 1 SET: we=1, data = action value masked to width, same addr/width; go to WRITE.
    - op 2 DROP: drop_o=1, ce=0, ready_o=1, go to DONE.
    - op 3: treated as NOP.
- WRITE: ce=0, we=0, ready_o=1, go to DONE. Exactly one write cycle.
- DONE: hold all outputs. When start_i=0, go to FREE; ready_o stays 1 until the next accepted start.
- mod_start_i outside FREE is dropped.
- Latency, start accepted to ready_o: 1 cycle (absent header), 2 (miss/NOP/DROP), 3 (SET).

Optional Feature:
- MA_HIT_COUNTER_EN:
  - Adds one 32-bit saturating hit counter per entry, incremented in the READ cycle of a hit.
  - Adds ports stat_idx_i (32, in) and stat_cnt_o (32, out, combinational read; 0 for out-of-range index).
  - Counters clear on rst and on a table-entry write to that index.
- Without the macro: no counters, no stat ports; behaviour otherwise identical.

Decomposition:
- Shared def.vh: NO_HEADER, MA state encodings (MA_STATE_FREE/READ/WRITE/DONE), action op codes (MA_OP_NOP/SET/DROP), MA_STATE_BUS.
- One natural sub-module, ma_lookup: combinational priority matcher taking field, width and the entry arrays; outputs hit and idx.

Test Plan:
- Key {hdr 1, off 2, w 2}; entry0 {val 0x0800, SET 0x86DD}; hdrs {0x100, 0x10E}; mem[0x110..0x111]=0x0800 -> read 0x110 w2, then write 0x86DD to 0x110 w2; hit_o=1, idx 0, drop_o=0, ready_o 3 cycles after start.
- Same key, entry2 {0x0806, DROP}, field 0x0806 -> no write; drop_o=1, idx 2, ready 2 cycles after start.
- entry0 and entry1 both match 0x0800 (entry1 SET) -> idx 0 wins, no write.
- Slot 1 = NO_HEADER -> mem_ce_o never asserted; hit_o=0, ready 1 cycle after start.
- mod_start_i and start_i in the same FREE cycle -> config written first, start taken the next cycle using the new config. start_i held high through DONE -> no re-trigger until it drops.
- rst asserted in READ with a SET hit pending -> no write cycle occurs; all outputs at reset values.
